// File: rtl/gcd_lcm_unit.sv
// ============================================================================
// gcd_lcm_unit
// ----------------------------------------------------------------------------
// Multi-cycle GCD/LCM coprocessor that sits behind the processor controller.
// The GCD uses the binary Stein algorithm, with one reduction step per cycle.
// The LCM reuses that GCD. It then performs an exact restoring division
// a0 / g and a shift-add multiply (a0 / g) * b0. The LCM is returned modulo
// 2^WIDTH, and an overflow flag reports any bits that were lost.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous, active-low reset
//   Start    - launch strobe, sampled every cycle; honoured only in IDLE/DONE
//   lcm_sel  - 0 = GCD, 1 = LCM; captured together with Start
//   SrcA     - operand a (unsigned), captured with Start
//   SrcB     - operand b (unsigned), captured with Start
//   busy     - high while an operation is in flight (GCD, DIV, MUL states)
//   done     - one-cycle pulse when Result/ovf are valid
//   Result   - GCD, or the low WIDTH bits of the LCM
//   ovf      - LCM needed more than WIDTH bits; always 0 for GCD
// ============================================================================
module gcd_lcm_unit #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             lcm_sel,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             ovf
);

    typedef enum logic [2:0] {
        IDLE,
        GCD,
        DIV,
        MUL,
        DONE
    } state_t;

    // The DIV and MUL phases each run exactly WIDTH cycles, counted 0..WIDTH-1.
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    state_t               state_q;

    // Captured operands and mode.
    logic [WIDTH-1:0]     a0_q;
    logic [WIDTH-1:0]     b0_q;
    logic                 lcmSel_q;

    // Stein working registers. k_q counts the shared factors of two.
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [CNTW-1:0]      k_q;

    // Divider: g_q is the divisor and rem_q the partial remainder.
    // quo_q first holds the dividend. It then shifts in the quotient bits
    // and, during MUL, acts as the multiplier.
    logic [WIDTH-1:0]     g_q;
    logic [WIDTH-1:0]     rem_q;
    logic [WIDTH-1:0]     quo_q;

    // Multiplier: double-width multiplicand and accumulator.
    logic [2*WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0]   acc_q;

    logic [CNTW-1:0]      cnt_q;

    // Registered outputs.
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     result_q;
    logic                 ovf_q;

    // Next-state values for one Stein step.
    logic [WIDTH-1:0]     a_d;
    logic [WIDTH-1:0]     b_d;
    logic [CNTW-1:0]      k_d;
    logic                 gcdExit;
    logic [WIDTH-1:0]     gcdVal;

    // Divider and multiplier step values.
    logic [WIDTH:0]       divShift;
    logic                 divGe;
    logic [WIDTH-1:0]     divDiff;
    logic [2*WIDTH-1:0]   accNext;
    logic                 cntLast;

    // One Stein step. Exactly one action is taken per cycle, in priority order.
    // When an operand reaches zero, the other operand, restored by the common
    // power of two, is the GCD.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        gcdExit = 1'b0;
        gcdVal  = '0;
        if (a_q == '0) begin
            gcdExit = 1'b1;
            gcdVal  = b_q << k_q;
        end else if (b_q == '0) begin
            gcdExit = 1'b1;
            gcdVal  = a_q << k_q;
        end else if (!a_q[0] && !b_q[0]) begin
            a_d = a_q >> 1;
            b_d = b_q >> 1;
            k_d = k_q + CNT_ONE;
        end else if (!a_q[0]) begin
            a_d = a_q >> 1;
        end else if (!b_q[0]) begin
            b_d = b_q >> 1;
        end else if (a_q >= b_q) begin
            a_d = a_q - b_q;
        end else begin
            b_d = b_q - a_q;
        end
    end

    // Restoring division step. The partial remainder is always below g,
    // so the shifted trial value is below 2g. Whenever the subtraction is
    // taken, the difference therefore fits in WIDTH bits.
    always_comb begin
        divShift = {rem_q, quo_q[WIDTH-1]};
        divGe    = (divShift >= {1'b0, g_q});
        divDiff  = divShift[WIDTH-1:0] - g_q;
    end

    // Shift-add multiply step. The multiplier LSB selects whether the
    // current multiplicand is added.
    always_comb begin
        accNext = quo_q[0] ? (acc_q + mcand_q) : acc_q;
        cntLast = (cnt_q == CNT_LAST);
    end

    // Control FSM and datapath registers. All outputs are registered.
    // The done pulse and the busy drop land together in the DONE cycle.
    // A Start seen in DONE relaunches immediately, without passing through IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            a0_q     <= '0;
            b0_q     <= '0;
            lcmSel_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            g_q      <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (Start) begin
                        a0_q     <= SrcA;
                        b0_q     <= SrcB;
                        lcmSel_q <= lcm_sel;
                        a_q      <= SrcA;
                        b_q      <= SrcB;
                        k_q      <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= GCD;
                    end else begin
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end

                GCD: begin
                    a_q <= a_d;
                    b_q <= b_d;
                    k_q <= k_d;
                    if (gcdExit) begin
                        if (!lcmSel_q) begin
                            result_q <= gcdVal;
                            ovf_q    <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else if ((a0_q == '0) || (b0_q == '0)) begin
                            // The LCM with a zero operand is zero. Skipping the
                            // divide also avoids a division by g = 0.
                            result_q <= '0;
                            ovf_q    <= 1'b0;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            g_q     <= gcdVal;
                            rem_q   <= '0;
                            quo_q   <= a0_q;
                            cnt_q   <= '0;
                            state_q <= DIV;
                        end
                    end
                end

                DIV: begin
                    rem_q <= divGe ? divDiff : divShift[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], divGe};
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cntLast) begin
                        cnt_q   <= '0;
                        mcand_q <= {{WIDTH{1'b0}}, b0_q};
                        acc_q   <= '0;
                        state_q <= MUL;
                    end
                end

                MUL: begin
                    acc_q   <= accNext;
                    mcand_q <= mcand_q << 1;
                    quo_q   <= quo_q >> 1;
                    cnt_q   <= cnt_q + CNT_ONE;
                    if (cntLast) begin
                        cnt_q    <= '0;
                        result_q <= accNext[WIDTH-1:0];
                        ovf_q    <= |accNext[2*WIDTH-1:WIDTH];
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Result = result_q;
    assign ovf    = ovf_q;

endmodule
